// File: rtl/fusion_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : fusion_result_serializer
// Brief   : Latches one fused result frame (6 state + 6 covariance words) and
//           streams it as sign-extended 32-bit words over valid/ready.
// Rev     : 1.0  initial release
// ============================================================================
module fusion_result_serializer #(
   parameter int XW   = 16,
   parameter int PW   = 32,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XW-1:0]   X0f,
   input  logic [XW-1:0]   X1f,
   input  logic [XW-1:0]   X2f,
   input  logic [XW-1:0]   X3f,
   input  logic [XW-1:0]   X4f,
   input  logic [XW-1:0]   X5f,
   input  logic [PW-1:0]   Pf1,
   input  logic [PW-1:0]   Pf2,
   input  logic [PW-1:0]   Pf3,
   input  logic [PW-1:0]   Pf4,
   input  logic [PW-1:0]   Pf5,
   input  logic [PW-1:0]   Pf6,
   output logic [31:0]     out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_idx,
   output logic            out_is_cov,
   output logic            out_last,
   output logic [CNTW-1:0] frame_cnt,
   output logic            busy
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   localparam logic [3:0] c_FIRST_COV = 4'd6;
   localparam logic [3:0] c_LAST_IDX  = 4'd11;

   state_t          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [XW-1:0]   x_q [6];
   logic [PW-1:0]   p_q [6];

   logic            w_capture;
   logic [31:0]     w_word;

   assign w_capture = (state_q == S_IDLE) && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // The bank is only written in IDLE, so input activity during SEND is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) begin
            x_q[i] <= '0;
            p_q[i] <= '0;
         end
      end else if (w_capture) begin
         x_q[0] <= X0f;
         x_q[1] <= X1f;
         x_q[2] <= X2f;
         x_q[3] <= X3f;
         x_q[4] <= X4f;
         x_q[5] <= X5f;
         p_q[0] <= Pf1;
         p_q[1] <= Pf2;
         p_q[2] <= Pf3;
         p_q[3] <= Pf4;
         p_q[4] <= Pf5;
         p_q[5] <= Pf6;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_SEND;
               idx_d   = '0;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               if (idx_q == c_LAST_IDX) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                  cnt_d   = cnt_q + CNTW'(1);
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Signed casts sign-extend each field to the 32-bit output word.
   always_comb begin
      w_word = '0;
      case (idx_q)
         4'd0:    w_word = 32'($signed(x_q[0]));
         4'd1:    w_word = 32'($signed(x_q[1]));
         4'd2:    w_word = 32'($signed(x_q[2]));
         4'd3:    w_word = 32'($signed(x_q[3]));
         4'd4:    w_word = 32'($signed(x_q[4]));
         4'd5:    w_word = 32'($signed(x_q[5]));
         4'd6:    w_word = 32'($signed(p_q[0]));
         4'd7:    w_word = 32'($signed(p_q[1]));
         4'd8:    w_word = 32'($signed(p_q[2]));
         4'd9:    w_word = 32'($signed(p_q[3]));
         4'd10:   w_word = 32'($signed(p_q[4]));
         4'd11:   w_word = 32'($signed(p_q[5]));
         default: w_word = '0;
      endcase
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_SEND);
   assign busy       = (state_q == S_SEND);
   assign out_data   = out_valid ? w_word : 32'd0;
   assign out_idx    = idx_q;
   assign out_is_cov = out_valid && (idx_q >= c_FIRST_COV);
   assign out_last   = out_valid && (idx_q == c_LAST_IDX);
   assign frame_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fusion_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fusion_result_serializer
// Brief   : Directed self-checking bench for fusion_result_serializer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fusion_result_serializer;

   localparam int XW   = 16;
   localparam int PW   = 32;
   localparam int CNTW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [XW-1:0]   xin [6];
   logic [PW-1:0]   pin [6];
   logic            in_ready;
   logic [31:0]     out_data;
   logic            out_valid;
   logic [3:0]      out_idx;
   logic            out_is_cov;
   logic            out_last;
   logic [CNTW-1:0] frame_cnt;
   logic            busy;

   logic [31:0]     exp_w [12];
   int              checks   = 0;
   int              failures = 0;

   always #5 clk = ~clk;

   fusion_result_serializer #(.XW(XW), .PW(PW), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .X0f        (xin[0]),
      .X1f        (xin[1]),
      .X2f        (xin[2]),
      .X3f        (xin[3]),
      .X4f        (xin[4]),
      .X5f        (xin[5]),
      .Pf1        (pin[0]),
      .Pf2        (pin[1]),
      .Pf3        (pin[2]),
      .Pf4        (pin[3]),
      .Pf5        (pin[4]),
      .Pf6        (pin[5]),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_is_cov (out_is_cov),
      .out_last   (out_last),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_inputs(input int xb, input int pb);
      for (int i = 0; i < 6; i++) begin
         xin[i] = XW'(xb + i);
         pin[i] = PW'(pb + i);
      end
   endtask

   task automatic set_exp(input int xb, input int pb);
      for (int i = 0; i < 6; i++) begin
         exp_w[i]     = 32'(xb + i);
         exp_w[6 + i] = 32'(pb + i);
      end
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic offer();
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // mode 0: always ready; mode 1: 5-cycle stall at idx 3, then alternate.
   task automatic recv_frame(input int mode, input int limit, input string tag);
      int          n   = 0;
      int          cyc = 0;
      int          st  = 0;
      int          sc  = 0;
      bit          tg  = 1'b1;
      bit          held = 1'b0;
      bit          rdy;
      logic [31:0] hd = '0;
      logic [3:0]  hi = '0;
      while (n < limit && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({tag, "_first_valid"}, out_valid, 1);
         rdy = 1'b1;
         if (mode == 1) begin
            if (st == 0 && out_valid && out_idx == 4'd3) st = 1;
            if (st == 1) begin
               rdy = 1'b0;
               sc++;
               if (sc == 5) st = 2;
            end else if (st == 2) begin
               rdy = tg;
               tg  = !tg;
            end
         end
         if (out_valid && held) begin
            check({tag, "_hold_data"}, out_data, hd);
            check({tag, "_hold_idx"}, out_idx, hi);
         end
         if (out_valid && rdy) begin
            check({tag, "_data"}, out_data, exp_w[n]);
            check({tag, "_idx"}, out_idx, n);
            check({tag, "_is_cov"}, out_is_cov, (n >= 6) ? 1 : 0);
            check({tag, "_last"}, out_last, (n == 11) ? 1 : 0);
            n++;
            held = 1'b0;
         end else begin
            held = out_valid;
            hd   = out_data;
            hi   = out_idx;
         end
         out_ready = rdy;
      end
      if (n < limit) check({tag, "_timeout"}, n, limit);
   endtask

   task automatic frame_end(input int exp_cnt);
      @(posedge clk);
      @(negedge clk);
      check("end_valid", out_valid, 0);
      check("end_busy", busy, 0);
      check("end_in_ready", in_ready, 1);
      check("frame_cnt", frame_cnt, exp_cnt);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_inputs(0, 0);
      // Reset state
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_idx", out_idx, 0);
      check("rst_cov", out_is_cov, 0);
      check("rst_last", out_last, 0);
      check("rst_cnt", frame_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      do_reset();

      // Single frame
      set_inputs(4, 12);
      set_exp(4, 12);
      offer();
      recv_frame(0, 12, "single");
      frame_end(1);

      // Sign extension
      xin[0] = 16'hFFF6; xin[1] = 16'h7FFF; xin[2] = 16'h8000;
      xin[3] = 16'h0000; xin[4] = 16'h0001; xin[5] = 16'hFFFF;
      pin[0] = 32'h80000000; pin[1] = 32'h7FFFFFFF; pin[2] = 32'hFFFFFFFF;
      pin[3] = 32'h00000000; pin[4] = 32'h00000005; pin[5] = 32'hFFFFFF00;
      exp_w[0] = 32'hFFFFFFF6; exp_w[1] = 32'h00007FFF; exp_w[2] = 32'hFFFF8000;
      exp_w[3] = 32'h00000000; exp_w[4] = 32'h00000001; exp_w[5] = 32'hFFFFFFFF;
      exp_w[6] = 32'h80000000; exp_w[7] = 32'h7FFFFFFF; exp_w[8] = 32'hFFFFFFFF;
      exp_w[9] = 32'h00000000; exp_w[10] = 32'h00000005; exp_w[11] = 32'hFFFFFF00;
      offer();
      recv_frame(0, 12, "sign");
      frame_end(2);

      // Backpressure
      set_inputs(50, 70);
      set_exp(50, 70);
      offer();
      recv_frame(1, 12, "bp");
      frame_end(3);

      // Inputs change while busy, next frame held pending on in_valid
      do_reset();
      set_inputs(20, 60);
      set_exp(20, 60);
      offer();
      set_inputs(40, 80);
      in_valid = 1'b1;
      recv_frame(0, 12, "busyA");
      @(posedge clk);
      @(negedge clk);
      check("gap_valid", out_valid, 0);
      check("gap_in_ready", in_ready, 1);
      check("gap_cnt", frame_cnt, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      set_exp(40, 80);
      recv_frame(0, 12, "busyB");
      frame_end(2);

      // Async reset mid-frame
      do_reset();
      set_inputs(1, 2);
      set_exp(1, 2);
      offer();
      recv_frame(0, 7, "rstmid");
      @(posedge clk);
      @(negedge clk);
      check("rstmid_pre_idx", out_idx, 7);
      rst_n = 1'b0;
      #1;
      check("rstmid_valid", out_valid, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_idx", out_idx, 0);
      check("rstmid_cnt", frame_cnt, 0);
      check("rstmid_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      set_inputs(200, 300);
      set_exp(200, 300);
      offer();
      recv_frame(0, 12, "postrst");
      frame_end(1);

      // Counter wrap
      do_reset();
      for (int f = 0; f < 256; f++) begin
         set_inputs(f, f + 1000);
         set_exp(f, f + 1000);
         offer();
         recv_frame(0, 12, "wrap");
         frame_end((f + 1) % 256);
      end
      check("wrap_final_cnt", frame_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
